adc_spi_xfer: RTL and testbench
===============================

ADC_SPI_XFER -- requirements
Module: adc_spi_xfer

Interface
REQ-001 Parameter DCLK_HALF, default 25: CLK cycles per DCLK half-period (1 MHz DCLK at 50 MHz CLK); legal range 2..255.
REQ-002 Parameter CMD_X, default 8'hD0: control byte for the X conversion (12-bit, differential, PENIRQ enabled).
REQ-003 Parameter CMD_Y, default 8'h90: control byte for the Y conversion.
REQ-004 CLK  input  1  system clock; all logic on its rising edge.
REQ-005 RST_n  input  1  asynchronous, active-low reset.
REQ-006 ENA_TRANS  input  1  level from the ADC control FSM; high requests an X then Y transfer.
REQ-007 FIN_TRANS  input  1  one-cycle pulse from the ADC control FSM; commits the captured coordinates.
REQ-008 ADC_DOUT  input  1  serial data from the ADC; synchronous to DCLK.
REQ-009 ADC_DCLK  output  1  serial clock to the ADC; idle low.
REQ-010 ADC_DIN  output  1  serial command data to the ADC, MSB first.
REQ-011 X_DONE  output  1  level; X frame complete (feeds FSM ENABLE_1).
REQ-012 Y_DONE  output  1  level; Y frame complete (feeds FSM ENABLE_2).
REQ-013 X_COORD  output  12  last committed X result.
REQ-014 Y_COORD  output  12  last committed Y result.
REQ-015 DATA_VALID  output  1  one-cycle pulse when X_COORD/Y_COORD are updated.

Function
REQ-016 The block SHALL implement states IDLE, XFER_X, XFER_Y, DONE.
REQ-017 IDLE -> XFER_X when ENA_TRANS=1; XFER_X -> XFER_Y after 24 DCLK periods; XFER_Y -> DONE after 24 DCLK periods; DONE -> IDLE when ENA_TRANS=0.
REQ-018 ENA_TRANS=0 in XFER_X or XFER_Y SHALL abort: next cycle IDLE, ADC_DCLK=0, ADC_DIN=0, counters cleared, shadow results not updated.
REQ-019 Each frame: DCLK low for DCLK_HALF cycles, then high for DCLK_HALF cycles, repeated 24 times (48*DCLK_HALF CLK cycles per frame); the frame begins with a low phase.
REQ-020 Rising edges within a frame are numbered k=0..23; ADC_DIN SHALL present command bit (7-k) during the low phase preceding edge k for k=0..7, and 0 otherwise.
REQ-021 ADC_DOUT SHALL be sampled on the CLK cycle in which ADC_DCLK rises; samples at edges k=9..20 form result bits 11..0 (MSB first); all other samples are ignored.
REQ-022 X result SHALL go to a 12-bit X shadow register and Y result to a Y shadow register, loaded only at completion of the respective frame.
REQ-023 X_DONE SHALL assert on the first cycle of XFER_Y and remain high until the state returns to IDLE; Y_DONE SHALL assert on the first cycle of DONE and remain high until IDLE.
REQ-024 A SHADOW_OK flag SHALL clear on entry to XFER_X and set on entry to DONE.
REQ-025 FIN_TRANS=1 with SHADOW_OK=1 SHALL copy both shadows to X_COORD/Y_COORD and pulse DATA_VALID exactly one cycle later; with SHADOW_OK=0 it SHALL be ignored.
REQ-026 FIN_TRANS arriving in the same cycle as ENA_TRANS falling in DONE SHALL still commit (SHADOW_OK is sampled before the IDLE transition).
REQ-027 X_COORD/Y_COORD SHALL hold their value between commits and after aborts.
REQ-028 ENA_TRANS held high in DONE SHALL NOT start a new transfer; a new transfer requires passing through IDLE.

Reset
REQ-029 RST_n=0 SHALL immediately force state IDLE, ADC_DCLK=0, ADC_DIN=0, X_DONE=0, Y_DONE=0, DATA_VALID=0, X_COORD=0, Y_COORD=0, shadows=0, SHADOW_OK=0, all counters 0, including mid-frame.
REQ-030 After RST_n rises, the block SHALL remain in IDLE until ENA_TRANS is sampled high.

Verification (DCLK_HALF=2)
REQ-031 ENA_TRANS rises, ADC model returns X=12'hA5C, Y=12'h3F1 -> ADC_DIN carries 8'hD0 then 8'h90 MSB first; X_DONE high 96 cycles after XFER_X entry, Y_DONE 96 cycles later.
REQ-032 FSM-style sequence: ENA_TRANS falls with a 1-cycle FIN_TRANS -> DATA_VALID pulses once, X_COORD=12'hA5C, Y_COORD=12'h3F1, X_DONE/Y_DONE clear.
REQ-033 ENA_TRANS drops at DCLK edge 12 of the Y frame, then FIN_TRANS pulses -> ADC_DCLK low next cycle, no DATA_VALID, coordinates unchanged.
REQ-034 RST_n asserted mid X frame -> all outputs 0 asynchronously; next ENA_TRANS yields a complete, correct frame.
REQ-035 ADC_DOUT all-ones, then all-zeros frames -> results 12'hFFF and 12'h000; bits outside edges 9..20 do not affect the result.
REQ-036 ENA_TRANS held high through DONE for 200 cycles -> no DCLK activity, X_DONE/Y_DONE stay high.

Source files
------------

// File: rtl/adc_spi_xfer.sv
// Purpose: SPI master for a touch-screen ADC. It sends the X command byte and then the Y
//          command byte, collects the two 12-bit results, and commits them on FIN_TRANS.
// Latency: 48*DCLK_HALF CLK cycles per frame. DATA_VALID and the new coordinates appear one
//          cycle after FIN_TRANS.
// Backpressure: none. ENA_TRANS is a level request, and dropping it aborts a frame at once.
//
// Ports:
//   CLK, RST_n            system clock, asynchronous active-low reset
//   ENA_TRANS, FIN_TRANS  request level and commit pulse from the ADC control FSM
//   ADC_DOUT              serial result bits from the ADC
//   ADC_DCLK, ADC_DIN     serial clock (idle low) and command bits to the ADC, MSB first
//   X_DONE, Y_DONE        frame-complete levels, held until the state returns to IDLE
//   X_COORD, Y_COORD      last committed results
//   DATA_VALID            one-cycle pulse when the coordinates are updated
module adc_spi_xfer #(
   parameter int unsigned DCLK_HALF = 25,
   parameter logic [7:0]  CMD_X     = 8'hD0,
   parameter logic [7:0]  CMD_Y     = 8'h90
) (
   input  logic        CLK,
   input  logic        RST_n,
   input  logic        ENA_TRANS,
   input  logic        FIN_TRANS,
   input  logic        ADC_DOUT,
   output logic        ADC_DCLK,
   output logic        ADC_DIN,
   output logic        X_DONE,
   output logic        Y_DONE,
   output logic [11:0] X_COORD,
   output logic [11:0] Y_COORD,
   output logic        DATA_VALID
);

   typedef enum logic [1:0] {IDLE, XFER_X, XFER_Y, DONE} state_t;

   localparam logic [7:0] HALF_LAST = 8'(DCLK_HALF - 1);
   localparam logic [4:0] EDGE_LAST = 5'd23;
   localparam logic [4:0] RES_FIRST = 5'd9;
   localparam logic [4:0] RES_LAST  = 5'd20;

   state_t      state_q, state_d;
   logic [7:0]  cyc_q, cyc_d;         // CLK cycles spent in the current DCLK half-period
   logic        hi_q, hi_d;           // current DCLK phase; this flop drives ADC_DCLK directly
   logic [4:0]  edge_q, edge_d;       // index k of the current DCLK period in the frame
   logic [11:0] sreg_q, sreg_d;       // result bits being assembled, MSB first
   logic [11:0] x_shadow_q, x_shadow_d;
   logic [11:0] y_shadow_q, y_shadow_d;
   logic        shadow_ok_q, shadow_ok_d;
   logic [11:0] x_coord_q, x_coord_d;
   logic [11:0] y_coord_q, y_coord_d;
   logic        dv_q, dv_d;

   logic        in_xfer;
   logic [7:0]  cmd_sel;

   assign in_xfer = (state_q == XFER_X) || (state_q == XFER_Y);
   assign cmd_sel = (state_q == XFER_Y) ? CMD_Y : CMD_X;

   // Command bit 7-k is driven in the low phase before edge k. It is also held through the
   // high phase that follows, so that ADC_DIN does not change on the same CLK edge where the
   // ADC samples it.
   assign ADC_DIN    = in_xfer && (edge_q < 5'd8) && cmd_sel[~edge_q[2:0]];
   assign ADC_DCLK   = hi_q;
   assign X_DONE     = (state_q == XFER_Y) || (state_q == DONE);
   assign Y_DONE     = (state_q == DONE);
   assign X_COORD    = x_coord_q;
   assign Y_COORD    = y_coord_q;
   assign DATA_VALID = dv_q;

   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      hi_d        = hi_q;
      edge_d      = edge_q;
      sreg_d      = sreg_q;
      x_shadow_d  = x_shadow_q;
      y_shadow_d  = y_shadow_q;
      shadow_ok_d = shadow_ok_q;
      x_coord_d   = x_coord_q;
      y_coord_d   = y_coord_q;
      dv_d        = 1'b0;

      case (state_q)
         IDLE: begin
            if (ENA_TRANS) begin
               state_d     = XFER_X;
               shadow_ok_d = 1'b0;
               sreg_d      = '0;
            end
         end
         XFER_X, XFER_Y: begin
            if (!ENA_TRANS) begin
               // Abort: return to a quiet bus. The shadow registers keep their old contents.
               state_d = IDLE;
               cyc_d   = '0;
               hi_d    = 1'b0;
               edge_d  = '0;
               sreg_d  = '0;
            end else if (cyc_q == HALF_LAST) begin
               cyc_d = '0;
               if (!hi_q) begin
                  // DCLK rises on this edge. Only edges 9..20 carry result bits.
                  hi_d = 1'b1;
                  if ((edge_q >= RES_FIRST) && (edge_q <= RES_LAST)) begin
                     sreg_d = {sreg_q[10:0], ADC_DOUT};
                  end
               end else begin
                  hi_d = 1'b0;
                  if (edge_q == EDGE_LAST) begin
                     edge_d = '0;
                     sreg_d = '0;
                     if (state_q == XFER_X) begin
                        x_shadow_d = sreg_q;
                        state_d    = XFER_Y;
                     end else begin
                        y_shadow_d  = sreg_q;
                        shadow_ok_d = 1'b1;
                        state_d     = DONE;
                     end
                  end else begin
                     edge_d = edge_q + 5'd1;
                  end
               end
            end else begin
               cyc_d = cyc_q + 8'd1;
            end
         end
         DONE: begin
            if (!ENA_TRANS) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // The commit uses the registered SHADOW_OK, so a FIN_TRANS in the same cycle that
      // DONE exits to IDLE still commits.
      if (FIN_TRANS && shadow_ok_q) begin
         x_coord_d = x_shadow_q;
         y_coord_d = y_shadow_q;
         dv_d      = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q     <= IDLE;
         cyc_q       <= '0;
         hi_q        <= 1'b0;
         edge_q      <= '0;
         sreg_q      <= '0;
         x_shadow_q  <= '0;
         y_shadow_q  <= '0;
         shadow_ok_q <= 1'b0;
         x_coord_q   <= '0;
         y_coord_q   <= '0;
         dv_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         hi_q        <= hi_d;
         edge_q      <= edge_d;
         sreg_q      <= sreg_d;
         x_shadow_q  <= x_shadow_d;
         y_shadow_q  <= y_shadow_d;
         shadow_ok_q <= shadow_ok_d;
         x_coord_q   <= x_coord_d;
         y_coord_q   <= y_coord_d;
         dv_q        <= dv_d;
      end
   end

endmodule

// File: tb/tb_adc_spi_xfer.sv
// Bench for adc_spi_xfer, built with DCLK_HALF=2.
// Latency under test: 96 CLK cycles per frame. DATA_VALID follows FIN_TRANS by one cycle.
// Backpressure: none. A simple ADC model serves each frame's bit pattern.
module tb_adc_spi_xfer;

   localparam int H  = 2;
   localparam int FR = 48 * H;

   logic        CLK = 1'b0;
   logic        RST_n = 1'b0;
   logic        ENA_TRANS = 1'b0;
   logic        FIN_TRANS = 1'b0;
   logic        ADC_DOUT;
   logic        ADC_DCLK, ADC_DIN, X_DONE, Y_DONE, DATA_VALID;
   logic [11:0] X_COORD, Y_COORD;

   always #5 CLK = ~CLK;

   adc_spi_xfer #(.DCLK_HALF(H), .CMD_X(8'hD0), .CMD_Y(8'h90)) dut (
      .CLK(CLK), .RST_n(RST_n), .ENA_TRANS(ENA_TRANS), .FIN_TRANS(FIN_TRANS),
      .ADC_DOUT(ADC_DOUT), .ADC_DCLK(ADC_DCLK), .ADC_DIN(ADC_DIN),
      .X_DONE(X_DONE), .Y_DONE(Y_DONE), .X_COORD(X_COORD), .Y_COORD(Y_COORD),
      .DATA_VALID(DATA_VALID)
   );

   int n_vec = 0;
   int n_bad = 0;

   // ADC model: after each DCLK fall it presents the bit for the next rising edge.
   // Bits 0..23 form the X frame, and bits 24..47 form the Y frame.
   logic [47:0] adc_bits = '0;
   int rise_cnt = 0;
   int neg_rise = 0;
   int base = 0;
   int idx;
   always @(posedge ADC_DCLK) rise_cnt <= rise_cnt + 1;
   always @(negedge ADC_DCLK) neg_rise <= rise_cnt;
   always_comb begin
      ADC_DOUT = 1'b0;
      idx = neg_rise - base;
      if (idx >= 0 && idx < 48) ADC_DOUT = adc_bits[idx];
   end

   function automatic logic [23:0] frame_bits(input logic [11:0] r, input logic [23:0] junk);
      logic [23:0] f;
      f = junk;
      for (int k = 9; k <= 20; k++) f[k] = r[20 - k];
      return f;
   endfunction

   // Behavioural model: the transfer runs for t = 0 .. 2*FR-1 cycles after it starts.
   // DCLK and DIN follow from t by arithmetic alone.
   logic [11:0] exp_x = '0, exp_y = '0;
   logic        m_act, m_done, m_ok, m_dv;
   int          m_t;
   logic [11:0] m_sx, m_sy, m_xc, m_yc;
   always @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         m_act <= 1'b0; m_done <= 1'b0; m_t <= 0; m_ok <= 1'b0; m_dv <= 1'b0;
         m_sx <= '0; m_sy <= '0; m_xc <= '0; m_yc <= '0;
      end else begin
         m_dv <= FIN_TRANS && m_ok;
         if (FIN_TRANS && m_ok) begin
            m_xc <= m_sx;
            m_yc <= m_sy;
         end
         if (!ENA_TRANS) begin
            m_act <= 1'b0; m_done <= 1'b0; m_t <= 0;
         end else if (!m_act && !m_done) begin
            m_act <= 1'b1; m_t <= 0; m_ok <= 1'b0;
         end else if (m_act) begin
            if (m_t == FR - 1) m_sx <= exp_x;
            if (m_t == 2 * FR - 1) begin
               m_sy <= exp_y; m_ok <= 1'b1; m_act <= 1'b0; m_done <= 1'b1;
            end else begin
               m_t <= m_t + 1;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      int k;
      logic hi;
      logic [7:0] cmd;
      k   = (m_t % FR) / (2 * H);
      hi  = (m_t % (2 * H)) >= H;
      cmd = (m_t < FR) ? 8'hD0 : 8'h90;
      chk("dclk", 32'(ADC_DCLK), 32'(m_act && hi));
      if (!m_act || k >= 8)  chk("din_zero", 32'(ADC_DIN), 0);
      else if (!hi)          chk("din_cmd", 32'(ADC_DIN), 32'(cmd[7 - k]));
      chk("x_done", 32'(X_DONE), 32'(m_done || (m_act && m_t >= FR)));
      chk("y_done", 32'(Y_DONE), 32'(m_done));
      chk("data_valid", 32'(DATA_VALID), 32'(m_dv));
      chk("x_coord", 32'(X_COORD), 32'(m_xc));
      chk("y_coord", 32'(Y_COORD), 32'(m_yc));
   endtask

   int tt;
   logic [7:0] cx, cy;

   task automatic step();
      @(posedge CLK);
      #1;
      tt++;
      compare_model();
   endtask

   task automatic start_xfer(input logic [11:0] x, input logic [11:0] y,
                             input logic [23:0] jx, input logic [23:0] jy);
      exp_x = x;
      exp_y = y;
      adc_bits = {frame_bits(y, jy), frame_bits(x, jx)};
      base = rise_cnt;
      cx = '0;
      cy = '0;
      ENA_TRANS = 1'b1;
      tt = -1;
      step();
   endtask

   task automatic run_until(input int n);
      while (tt < n) begin
         step();
         if ((tt % (2 * H)) == H - 1 && ((tt % FR) / (2 * H)) < 8) begin
            if (tt < FR) cx = {cx[6:0], ADC_DIN};
            else         cy = {cy[6:0], ADC_DIN};
         end
         if (tt == FR - 1)     chk("x_done_early", 32'(X_DONE), 0);
         if (tt == FR)         chk("x_done_at_96", 32'(X_DONE), 1);
         if (tt == 2 * FR - 1) chk("y_done_early", 32'(Y_DONE), 0);
         if (tt == 2 * FR)     chk("y_done_at_192", 32'(Y_DONE), 1);
      end
   endtask

   task automatic full_xfer(input logic [11:0] x, input logic [11:0] y,
                            input logic [23:0] jx, input logic [23:0] jy);
      start_xfer(x, y, jx, jy);
      run_until(2 * FR);
      chk("cmd_x_byte", 32'(cx), 32'hD0);
      chk("cmd_y_byte", 32'(cy), 32'h90);
   endtask

   task automatic commit(input logic [11:0] ex, input logic [11:0] ey);
      ENA_TRANS = 1'b0;
      FIN_TRANS = 1'b1;
      step();
      FIN_TRANS = 1'b0;
      chk("commit_dv", 32'(DATA_VALID), 1);
      chk("commit_x", 32'(X_COORD), 32'(ex));
      chk("commit_y", 32'(Y_COORD), 32'(ey));
      step();
      chk("dv_one_cycle", 32'(DATA_VALID), 0);
      chk("x_done_clear", 32'(X_DONE), 0);
      chk("y_done_clear", 32'(Y_DONE), 0);
   endtask

   initial begin
      int r0;
      tt = 0;
      repeat (3) step();
      chk("rst_dclk", 32'(ADC_DCLK), 0);
      chk("rst_xc", 32'(X_COORD), 0);
      chk("rst_dv", 32'(DATA_VALID), 0);
      RST_n = 1'b1;
      repeat (5) step();
      chk("idle_x_done", 32'(X_DONE), 0);

      // Basic X then Y transfer, committed by the FSM-style sequence.
      full_xfer(12'hA5C, 12'h3F1, 24'h5A5A5A, 24'hC3C3C3);
      commit(12'hA5C, 12'h3F1);
      repeat (3) step();

      // Abort at DCLK edge 12 of the Y frame, followed by a FIN_TRANS that must be ignored.
      start_xfer(12'h123, 12'h456, 24'h0, 24'h0);
      run_until(FR + 12 * 2 * H + H);
      chk("abort_dclk_high", 32'(ADC_DCLK), 1);
      ENA_TRANS = 1'b0;
      step();
      chk("abort_dclk_low", 32'(ADC_DCLK), 0);
      FIN_TRANS = 1'b1;
      step();
      FIN_TRANS = 1'b0;
      step();
      chk("abort_no_dv", 32'(DATA_VALID), 0);
      chk("abort_hold_x", 32'(X_COORD), 32'hA5C);
      chk("abort_hold_y", 32'(Y_COORD), 32'h3F1);

      // Asynchronous reset in the middle of the X frame, asserted while DCLK is high.
      start_xfer(12'h7E4, 12'h0B9, 24'hFFFFFF, 24'h000000);
      run_until(30);
      chk("pre_rst_dclk", 32'(ADC_DCLK), 1);
      #2 RST_n = 1'b0;
      #1;
      chk("arst_dclk", 32'(ADC_DCLK), 0);
      chk("arst_din", 32'(ADC_DIN), 0);
      chk("arst_x_done", 32'(X_DONE), 0);
      chk("arst_y_done", 32'(Y_DONE), 0);
      chk("arst_dv", 32'(DATA_VALID), 0);
      chk("arst_xc", 32'(X_COORD), 0);
      chk("arst_yc", 32'(Y_COORD), 0);
      ENA_TRANS = 1'b0;
      repeat (2) step();
      RST_n = 1'b1;
      repeat (3) step();
      full_xfer(12'h7E4, 12'h0B9, 24'hFFFFFF, 24'h000000);
      commit(12'h7E4, 12'h0B9);

      // All-ones and all-zeros frames, then the same results with the opposite ignored bits.
      full_xfer(12'hFFF, 12'h000, 24'hFFFFFF, 24'h000000);
      commit(12'hFFF, 12'h000);
      full_xfer(12'h000, 12'hFFF, 24'hFFFFFF, 24'h000000);
      commit(12'h000, 12'hFFF);

      // ENA_TRANS held high in DONE must not start another frame.
      full_xfer(12'hA5C, 12'h3F1, 24'h123456, 24'hABCDEF);
      r0 = rise_cnt;
      repeat (200) step();
      chk("done_no_dclk", 32'(rise_cnt - r0), 0);
      chk("done_x_done", 32'(X_DONE), 1);
      chk("done_y_done", 32'(Y_DONE), 1);
      commit(12'hA5C, 12'h3F1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
